// File: rtl/class_hv_readout.sv
// Class HV readout: streams the binarized class HVs of the masked classes
// as WORD_W-bit words over a valid/ready port, class by class.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   en                  global advance enable (everything frozen when low)
//   start_readout       one-cycle request pulse
//   class_gen_done      class HVs valid and stable while high
//   class_mask          classes to dump, latched on an accepted start
//   bin_class_hvs       flat HVs: class k, chunk c, bit b at (k*SEQ+c)*DIMS+b
//   out_valid/ready     word handshake
//   out_data/class/last word payload, its class index, final-word flag
//   busy                FSM not in IDLE
//   readout_done, err   one-cycle completion / reject-or-abort pulses
module class_hv_readout #(
    parameter int CLASS_COUNT     = 26,
    parameter int SEQ_CYCLE_COUNT = 5,
    parameter int DIMS_PER_CC     = 1000,
    parameter int WORD_W          = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                start_readout,
    input  logic                class_gen_done,
    input  logic [CLASS_COUNT-1:0] class_mask,
    input  logic [CLASS_COUNT*SEQ_CYCLE_COUNT*DIMS_PER_CC-1:0] bin_class_hvs,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WORD_W-1:0]   out_data,
    output logic [4:0]          out_class,
    output logic                out_last,
    output logic                busy,
    output logic                readout_done,
    output logic                err
);
    localparam int WPC  = (DIMS_PER_CC + WORD_W - 1) / WORD_W;
    localparam int PADW = WPC * WORD_W;
    localparam int HVW  = CLASS_COUNT * SEQ_CYCLE_COUNT * DIMS_PER_CC;
    localparam int HIW  = $clog2(HVW);
    localparam int PIW  = (PADW > 1) ? $clog2(PADW) : 1;
    localparam int KW   = (CLASS_COUNT > 1) ? $clog2(CLASS_COUNT) : 1;
    localparam int CW   = (SEQ_CYCLE_COUNT > 1) ? $clog2(SEQ_CYCLE_COUNT) : 1;
    localparam int WW   = (WPC > 1) ? $clog2(WPC) : 1;

    typedef enum logic [1:0] {IDLE, SEEK, SEND, FLUSH} state_t;

    state_t                 state_q, state_d;
    logic [CLASS_COUNT-1:0] mask_q, mask_d;
    logic [KW-1:0]          cls_q, cls_d;
    logic [CW-1:0]          chk_q, chk_d;
    logic [WW-1:0]          wrd_q, wrd_d;
    logic                   valid_q, valid_d;
    logic [WORD_W-1:0]      data_q, data_d;
    logic                   last_q, last_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic                   above;
    logic                   hs;
    logic                   cls_end;
    logic [CW-1:0]          nxt_c, f_c;
    logic [WW-1:0]          nxt_w, f_w;
    logic                   f_last;
    logic [HIW-1:0]         hv_base;
    logic [PIW-1:0]         w_base;
    logic [DIMS_PER_CC-1:0] chunk;
    logic [PADW-1:0]        padded;
    logic [WORD_W-1:0]      f_word;

    // any masked class strictly above the current one
    always_comb begin
        above = 1'b0;
        for (int k = 0; k < CLASS_COUNT; k++) begin
            if (k > int'(cls_q) && mask_q[k]) above = 1'b1;
        end
    end

    assign hs      = valid_q & out_ready;
    assign cls_end = (chk_q == CW'(SEQ_CYCLE_COUNT - 1)) &&
                     (wrd_q == WW'(WPC - 1));

    // single word fetch: word 0 when leaving SEEK, else the successor
    always_comb begin
        if (wrd_q == WW'(WPC - 1)) begin
            nxt_w = '0;
            nxt_c = chk_q + CW'(1);
        end else begin
            nxt_w = wrd_q + WW'(1);
            nxt_c = chk_q;
        end
        f_c     = (state_q == SEEK) ? '0 : nxt_c;
        f_w     = (state_q == SEEK) ? '0 : nxt_w;
        f_last  = (f_c == CW'(SEQ_CYCLE_COUNT - 1)) &&
                  (f_w == WW'(WPC - 1)) && !above;
        hv_base = HIW'((int'(cls_q) * SEQ_CYCLE_COUNT + int'(f_c)) * DIMS_PER_CC);
        chunk   = bin_class_hvs[hv_base +: DIMS_PER_CC];
        // zero padding supplies the unused top bits of the last word
        padded  = '0;
        padded[DIMS_PER_CC-1:0] = chunk;
        w_base  = PIW'(int'(f_w) * WORD_W);
        f_word  = padded[w_base +: WORD_W];
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        cls_d   = cls_q;
        chk_d   = chk_q;
        wrd_d   = wrd_q;
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_readout) begin
                    if (!class_gen_done) begin
                        err_d = 1'b1;
                    end else if (class_mask == '0) begin
                        done_d = 1'b1;
                    end else begin
                        mask_d  = class_mask;
                        cls_d   = '0;
                        chk_d   = '0;
                        wrd_d   = '0;
                        state_d = SEEK;
                    end
                end
            end
            SEEK: begin
                if (!class_gen_done) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (mask_q[cls_q]) begin
                    data_d  = f_word;
                    last_d  = f_last;
                    chk_d   = '0;
                    wrd_d   = '0;
                    state_d = SEND;
                end else if (!above) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cls_d = cls_q + KW'(1);
                end
            end
            SEND: begin
                if (!valid_q) begin
                    // word loaded last cycle; raise valid now
                    if (!class_gen_done) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        valid_d = 1'b1;
                    end
                end else if (hs) begin
                    if (!class_gen_done) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else if (cls_end) begin
                        valid_d = 1'b0;
                        cls_d   = cls_q + KW'(1);
                        state_d = SEEK;
                    end else begin
                        data_d = f_word;
                        last_d = f_last;
                        chk_d  = nxt_c;
                        wrd_d  = nxt_w;
                    end
                end else if (!class_gen_done) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (hs) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mask_q  <= '0;
            cls_q   <= '0;
            chk_q   <= '0;
            wrd_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // strobes never stretch, even when en freezes the rest
            done_q <= en & done_d;
            err_q  <= en & err_d;
            if (en) begin
                state_q <= state_d;
                mask_q  <= mask_d;
                cls_q   <= cls_d;
                chk_q   <= chk_d;
                wrd_q   <= wrd_d;
                valid_q <= valid_d;
                data_q  <= data_d;
                last_q  <= last_d;
            end
        end
    end

    assign out_valid    = valid_q;
    assign out_data     = data_q;
    assign out_class    = 5'(cls_q);
    assign out_last     = last_q;
    assign busy         = (state_q != IDLE);
    assign readout_done = done_q;
    assign err          = err_q;
endmodule

// File: tb/tb_class_hv_readout.sv
// Bench for class_hv_readout: directed runs with random HV contents
// checked against a word-list model built from the class/chunk/word rules.
module tb_class_hv_readout;
    localparam int NC = 4;
    localparam int NS = 2;
    localparam int ND = 40;
    localparam int W  = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en = 1'b1;
    logic            start_readout = 1'b0;
    logic            class_gen_done = 1'b1;
    logic [NC-1:0]   class_mask = '0;
    logic [NC*NS*ND-1:0] hv = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [W-1:0]    out_data;
    logic [4:0]      out_class;
    logic            out_last;
    logic            busy;
    logic            readout_done;
    logic            err;

    int total = 0;
    int bad = 0;

    logic [31:0] got_d[$];
    int          got_c[$];
    logic        got_l[$];
    logic [31:0] exp_d[$];
    int          exp_c[$];
    logic        exp_l[$];
    int first_v, done_c, err_c, last_hs, unstable;

    class_hv_readout #(
        .CLASS_COUNT(NC), .SEQ_CYCLE_COUNT(NS),
        .DIMS_PER_CC(ND), .WORD_W(W)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .start_readout(start_readout),
        .class_gen_done(class_gen_done),
        .class_mask(class_mask),
        .bin_class_hvs(hv),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_class(out_class),
        .out_last(out_last), .busy(busy),
        .readout_done(readout_done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_hv();
        for (int i = 0; i < NC*NS*ND/32; i++) hv[i*32 +: 32] = $urandom;
    endtask

    // expected words: ascending class, chunk, word; zero past ND bits
    task automatic build(input logic [NC-1:0] m);
        logic [31:0] v;
        exp_d.delete(); exp_c.delete(); exp_l.delete();
        for (int k = 0; k < NC; k++) begin
            if (m[k]) begin
                for (int c = 0; c < NS; c++) begin
                    for (int w = 0; w * W < ND; w++) begin
                        v = '0;
                        for (int j = 0; j < W; j++)
                            if (w * W + j < ND) v[j] = hv[(k*NS + c)*ND + w*W + j];
                        exp_d.push_back(v);
                        exp_c.push_back(k);
                        exp_l.push_back(1'b0);
                    end
                end
            end
        end
        if (exp_l.size() > 0) exp_l[exp_l.size()-1] = 1'b1;
    endtask

    task automatic do_start(input logic [NC-1:0] m);
        class_mask = m;
        start_readout = 1'b1;
        tick();
        start_readout = 1'b0;
    endtask

    // mode 0: ready=1; 1: ready toggles + stray start; 2: drop
    // class_gen_done on 2nd word; 3: en=0 for 3 cycles after 2 words
    task automatic collect(input int mode, input int budget);
        logic pv, pr, pe, pl;
        logic [31:0] pd;
        logic [4:0] pc;
        int frz;
        bit dropped;
        got_d.delete(); got_c.delete(); got_l.delete();
        first_v = -1; done_c = -1; err_c = -1; last_hs = -1; unstable = 0;
        pv = 0; pr = 0; pe = 1; pl = 0; pd = '0; pc = '0;
        frz = 0; dropped = 0;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            tick();
            if (pv && (!pr || !pe)) begin
                if ({out_valid, out_data, out_class, out_last} !== {pv, pd, pc, pl})
                    unstable++;
            end
            if (out_valid && first_v < 0) first_v = cyc;
            if (readout_done && done_c < 0) done_c = cyc;
            if (err && err_c < 0) err_c = cyc;
            if (done_c >= 0 || err_c >= 0) break;
            start_readout = 1'b0;
            en = 1'b1;
            case (mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = (cyc % 2) == 1;
                    if (cyc == 3) start_readout = 1'b1;
                end
                2: begin
                    if (!dropped && out_valid && got_d.size() == 1) begin
                        class_gen_done = 1'b0;
                        out_ready = 1'b0;
                        dropped = 1;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: begin
                    out_ready = 1'b1;
                    if (frz == 0 && out_valid && got_d.size() == 2) frz = 1;
                    if (frz >= 1 && frz <= 3) begin
                        en = 1'b0;
                        frz++;
                    end
                end
            endcase
            if (out_valid && out_ready && en) begin
                got_d.push_back(out_data);
                got_c.push_back(int'(out_class));
                got_l.push_back(out_last);
                last_hs = cyc;
            end
            pv = out_valid; pr = out_ready; pe = en;
            pd = out_data; pc = out_class; pl = out_last;
        end
        chk("no_timeout", (done_c >= 0 || err_c >= 0), 1);
        en = 1'b1;
        start_readout = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic cmp_words(input string tag, input int n);
        chk({tag, "_nwords"}, got_d.size(), n);
        for (int i = 0; i < n && i < got_d.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), got_d[i], exp_d[i]);
            chk($sformatf("%s_class%0d", tag, i), got_c[i], exp_c[i]);
            chk($sformatf("%s_last%0d", tag, i), got_l[i], exp_l[i]);
        end
    endtask

    initial begin
        rand_hv();
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", readout_done, 0);
        chk("rst_err", err, 0);
        chk("rst_data", out_data, 0);
        chk("rst_class", out_class, 0);
        chk("rst_last", out_last, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // mask 0101, always ready
        out_ready = 1'b1;
        build(4'b0101);
        do_start(4'b0101);
        collect(0, 60);
        chk("A_first_valid", first_v, 2);
        chk("A_done_lat", done_c, last_hs + 1);
        chk("A_no_err", err_c, -1);
        cmp_words("A", 8);
        if (got_d.size() > 1) chk("A_pad", got_d[1][31:8], 0);
        chk("A_busy_end", busy, 0);
        tick();
        chk("A_done_pulse", readout_done, 0);

        // mask 1000, ready toggling, stray start while busy
        rand_hv();
        build(4'b1000);
        do_start(4'b1000);
        collect(1, 80);
        chk("B_first_valid", first_v, 5);
        chk("B_done_lat", done_c, last_hs + 1);
        chk("B_no_err", err_c, -1);
        chk("B_stable", unstable, 0);
        cmp_words("B", 4);
        chk("B_busy_end", busy, 0);

        // start rejected without class_gen_done
        class_gen_done = 1'b0;
        do_start(4'b0101);
        chk("C_err", err, 1);
        chk("C_busy", busy, 0);
        chk("C_valid", out_valid, 0);
        chk("C_done", readout_done, 0);
        tick();
        chk("C_err_pulse", err, 0);
        chk("C_valid2", out_valid, 0);
        class_gen_done = 1'b1;

        // empty mask completes at once
        do_start(4'b0000);
        chk("C0_done", readout_done, 1);
        chk("C0_busy", busy, 0);
        chk("C0_valid", out_valid, 0);
        tick();
        chk("C0_done_pulse", readout_done, 0);
        chk("C0_valid2", out_valid, 0);

        // class_gen_done dropped on 2nd word of class 1
        rand_hv();
        build(4'b0010);
        out_ready = 1'b1;
        do_start(4'b0010);
        collect(2, 60);
        class_gen_done = 1'b1;
        cmp_words("D", 2);
        chk("D_err_lat", err_c, last_hs + 1);
        chk("D_no_done", done_c, -1);
        chk("D_stable", unstable, 0);
        chk("D_busy_end", busy, 0);

        // reset mid-SEND, then a fresh run with an en=0 freeze
        rand_hv();
        out_ready = 1'b1;
        do_start(4'b1111);
        for (int n = 0; n < 10 && !out_valid; n++) tick();
        chk("E_valid_seen", out_valid, 1);
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("E_rst_valid", out_valid, 0);
        chk("E_rst_busy", busy, 0);
        chk("E_rst_data", out_data, 0);
        chk("E_rst_class", out_class, 0);
        chk("E_rst_last", out_last, 0);
        chk("E_rst_done", readout_done, 0);
        chk("E_rst_err", err, 0);
        tick();
        rst = 1'b0;
        tick();
        build(4'b0110);
        do_start(4'b0110);
        collect(3, 80);
        chk("E_first_valid", first_v, 3);
        chk("E_done_lat", done_c, last_hs + 1);
        chk("E_no_err", err_c, -1);
        chk("E_stable", unstable, 0);
        cmp_words("E", 8);
        chk("E_busy_end", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/class_hv_readout.md
CLASS_HV_READOUT -- requirements
Module: class_hv_readout

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- CLASS_COUNT, 26, number of class HVs.
- SEQ_CYCLE_COUNT, 5, chunks per class HV.
- DIMS_PER_CC, 1000, bits per chunk.
- WORD_W, 32, output word width.
REQ-002 Derived: WPC = ceil(DIMS_PER_CC/WORD_W) words per chunk; WPCL = SEQ_CYCLE_COUNT*WPC words per class.
REQ-003 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, single clock; all logic on the rising edge.
- rst, in, 1, asynchronous active-high reset.
- en, in, 1, global advance enable.
- start_readout, in, 1, one-cycle request pulse.
- class_gen_done, in, 1, level; high while class HVs are valid and stable.
- class_mask, in, CLASS_COUNT, classes to dump; sampled on an accepted start.
- bin_class_hvs, in, CLASS_COUNT x [SEQ_CYCLE_COUNT][DIMS_PER_CC], binarized class HVs.
- out_valid, out, 1, word valid.
- out_ready, in, 1, consumer ready.
- out_data, out, WORD_W, word payload.
- out_class, out, 5, class index of the current word.
- out_last, out, 1, final word of the dump.
- busy, out, 1, high in any state other than IDLE.
- readout_done, out, 1, one-cycle pulse at completion.
- err, out, 1, one-cycle pulse on a rejected start or an abort.

Function
REQ-004 FSM states SHALL be IDLE, SEEK, SEND and FLUSH; the reset state is IDLE.
REQ-005 A start is accepted when start_readout=1, en=1, state=IDLE and class_gen_done=1. On acceptance the block SHALL latch class_mask, set class_idx=0, chunk_idx=0, word_idx=0 and go to SEEK.
REQ-006 start_readout in IDLE with class_gen_done=0 SHALL pulse err the next cycle and stay in IDLE.
REQ-007 start_readout outside IDLE SHALL be ignored, with no err.
REQ-008 An accepted start with latched mask=0 SHALL pulse readout_done the next cycle, emit no words and return to IDLE.
REQ-009 SEEK SHALL examine one class_idx per enabled cycle:
- Mask bit set: load word 0 of that class into the output register, go to SEND.
- Mask bit clear: increment class_idx.
- No set bit remains: pulse readout_done, go to IDLE.
REQ-010 Word order SHALL be ascending class, then chunk 0..SEQ_CYCLE_COUNT-1, then word 0..WPC-1.
REQ-011 Word w of chunk c SHALL carry bits [w*WORD_W +: WORD_W] of chunk c. Bits beyond DIMS_PER_CC in the last word SHALL be 0.
REQ-012 In SEND, out_valid=1. out_data, out_class and out_last SHALL stay stable until out_valid&out_ready is sampled with en=1.
REQ-013 On a handshake, if more words remain in the class, the next word SHALL be presented in the following cycle with no bubble.
REQ-014 On a handshake of the last word of a class, the FSM SHALL go to SEEK with class_idx+1 and drop out_valid for at least one cycle.
REQ-015 out_last SHALL be 1 only on the last word of the highest-index masked class; that word's handshake SHALL pulse readout_done the next cycle and return the FSM to IDLE.
REQ-016 While en=0:
- no counter, state or output register SHALL change;
- out_valid SHALL hold its value;
- handshakes SHALL not be counted.
REQ-017 If class_gen_done falls while busy:
- in SEEK, go to IDLE and pulse err;
- in SEND, go to FLUSH; the pending word completes its handshake, then err pulses and the FSM returns to IDLE;
- readout_done SHALL not pulse in either case.
REQ-018 The first out_valid SHALL rise 2 cycles after the accepting edge when class 0 is masked, plus 1 cycle per skipped class.
REQ-019 Counter widths SHALL be ceil(log2) of their ranges. class_idx SHALL never exceed CLASS_COUNT-1, and no counter SHALL wrap.

Reset
REQ-020 rst=1 SHALL asynchronously force state=IDLE, all counters=0, and out_valid, out_data, out_class, out_last, busy, readout_done and err all to 0, including mid-SEND.
REQ-021 After rst deasserts, the block SHALL accept a new start with no residual state.

Verification
Bench parameters: CLASS_COUNT=4, SEQ_CYCLE_COUNT=2, DIMS_PER_CC=40, WORD_W=32 (WPC=2, WPCL=4).
REQ-022 Mask 4'b0101, out_ready=1 -> 8 words: class 0 then class 2; word1 upper 24 bits = 0; out_last on the 8th word only; readout_done 1 cycle later.
REQ-023 Mask 4'b1000, out_ready toggled every cycle -> 4 words of class 3 stay stable across stalls; first out_valid at accept+5.
REQ-024 start with class_gen_done=0 -> err pulse, busy=0, no out_valid; start with mask=0 -> readout_done pulse, no words.
REQ-025 class_gen_done dropped during the 2nd word of class 1 -> that word completes, err pulses, readout_done stays 0, FSM returns to IDLE.
REQ-026 rst asserted during SEND, then en=0 held 3 cycles on a new run -> outputs clear immediately; during the en=0 cycles outputs freeze and no words are lost or duplicated.
